// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 9;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALTED} fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // PC advance; wraps modulo 2**ADDR_W by construction.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO of {pc, instr} entries; read data is the head, visible one cycle after push.
// Push on full only succeeds alongside a pop; pop on empty is ignored; flush empties it.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     wdata_i,
  output fetch_entry_t     rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != DEPTH_C) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked only by count_q.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, fetch FSM and redirect handling; start -> imem_addr next cycle -> head valid after.
// Stalls (pc and imem_addr hold) while the FIFO is full and decode does not pop.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               inst_valid,
  output logic [INSTR_W-1:0] inst_data,
  output logic [ADDR_W-1:0]  inst_pc,
  input  logic               inst_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               halted,
  output logic               busy
);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, busy_q;

  fetch_entry_t      head, wentry;
  logic              fifo_empty, fifo_full;
  logic              redir, pop, push, halt_pop, idle_like;

  assign idle_like = (state_q == IDLE) || (state_q == HALTED);
  // A redirect squashes both the pop and the push of its cycle.
  assign redir    = redirect_valid && ((state_q == FETCH) || (state_q == DRAIN));
  assign pop      = inst_ready && !fifo_empty && !redir;
  assign push     = (state_q == FETCH) && !redir && (!fifo_full || pop);
  assign halt_pop = (state_q == DRAIN) && pop && (head.instr == HALT_INSTR);

  assign wentry.pc    = pc_q;
  assign wentry.instr = imem_instr;

  always_comb begin
    pc_d = pc_q;
    if (idle_like && start)                        pc_d = '0;
    else if (redir)                                pc_d = redirect_target;
    else if (push && (imem_instr != HALT_INSTR))   pc_d = pc_inc(pc_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      halted_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        IDLE, HALTED: begin
          if (start) begin
            state_q  <= FETCH;
            halted_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        FETCH: begin
          if (push && (imem_instr == HALT_INSTR)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (redir) begin
            state_q <= FETCH;
          end else if (halt_pop) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redir),
    .wdata_i (wentry),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign imem_addr  = pc_q;
  assign inst_valid = !fifo_empty;
  assign inst_data  = head.instr;
  assign inst_pc    = head.pc;
  assign halted     = halted_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected deliveries queued by stimulus, popped by a negedge monitor.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic               clk = 1'b0;
  logic               reset, start, inst_ready, redirect_valid;
  logic [ADDR_W-1:0]  redirect_target, imem_addr, inst_pc;
  logic [INSTR_W-1:0] imem_instr, inst_data;
  logic               inst_valid, halted, busy;

  logic [INSTR_W-1:0] mem [0:31];
  fetch_entry_t       exp_q [$];
  fetch_entry_t       mon_e;
  int                 total = 0;
  int                 bad = 0;
  int                 c;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr];

  fetch_unit #(.DEPTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halted          (halted),
    .busy            (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every accepted head must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected delivery: pc=%0d instr=%0h expected none", inst_pc, inst_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("deliver{pc,instr}", {inst_pc, inst_data}, {mon_e.pc, mon_e.instr});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input int first, input int n);
    fetch_entry_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = ADDR_W'((first + i) % 32);
      e.instr = mem[(first + i) % 32];
      exp_q.push_back(e);
    end
  endtask

  // Hold ready high until n heads have been accepted; reports negedges spent.
  task automatic deliver(input int n, output int cycles);
    int got;
    got = 0;
    cycles = 0;
    inst_ready = 1'b1;
    while (got < n && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (inst_valid) got++;
    end
    if (got < n) begin
      total++;
      bad++;
      $display("FAIL deliver timeout: got %0d of %0d", got, n);
    end
    @(posedge clk);
    #1;
    inst_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    for (int a = 0; a < 32; a++) mem[a] = INSTR_W'(a + 1);

    // Reset state
    cyc(2);
    @(negedge clk);
    chk("rst inst_valid", inst_valid, 0);
    chk("rst imem_addr", imem_addr, 0);
    chk("rst halted", halted, 0);
    chk("rst busy", busy, 0);
    cyc(1);
    reset = 1'b0;

    // Streaming with ready=1: first head two cycles after start, then one per cycle
    pulse_start();
    @(negedge clk);
    chk("t1 imem_addr after start", imem_addr, 0);
    chk("t1 valid after start", inst_valid, 0);
    chk("t1 busy", busy, 1);
    expect_pc(0, 8);
    cyc(1);
    deliver(8, c);
    chk("t1 cycles for 8", c, 8);

    // Backpressure: FIFO fills with pc 0,1 and imem_addr holds at 2
    do_reset();
    pulse_start();
    cyc(5);
    @(negedge clk);
    chk("t2 imem_addr hold", imem_addr, 2);
    chk("t2 valid", inst_valid, 1);
    chk("t2 head pc", inst_pc, 0);
    chk("t2 head data", inst_data, 1);
    expect_pc(0, 4);
    cyc(1);
    deliver(4, c);
    chk("t2 cycles for 4", c, 4);

    // Redirect to 20 while FIFO holds 5,6 with ready=1
    do_reset();
    pulse_start();
    expect_pc(0, 5);
    deliver(5, c);
    chk("t3 cycles for 5", c, 6);
    cyc(1);
    redirect_valid = 1'b1; redirect_target = 5'd20; inst_ready = 1'b1;
    @(negedge clk);
    chk("t3 head before redirect", inst_pc, 5);
    chk("t3 imem_addr before redirect", imem_addr, 7);
    cyc(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3 flushed", inst_valid, 0);
    chk("t3 imem_addr target", imem_addr, 20);
    expect_pc(20, 3);
    cyc(1);
    deliver(3, c);
    chk("t3 cycles for 3", c, 3);

    // HALT at address 3
    do_reset();
    mem[3] = HALT_INSTR;
    expect_pc(0, 4);
    pulse_start();
    deliver(4, c);
    chk("t4 cycles for 4", c, 5);
    @(negedge clk);
    chk("t4 halted", halted, 1);
    chk("t4 busy", busy, 0);
    chk("t4 no valid", inst_valid, 0);
    chk("t4 pc holds", imem_addr, 3);
    cyc(3);
    @(negedge clk);
    chk("t4 halted stays", halted, 1);
    chk("t4 pc still holds", imem_addr, 3);
    cyc(1);
    pulse_start();
    @(negedge clk);
    chk("t4 restart halted", halted, 0);
    chk("t4 restart busy", busy, 1);
    chk("t4 restart addr", imem_addr, 0);
    expect_pc(0, 2);
    cyc(1);
    deliver(2, c);

    // HALT at 3 speculative: redirect to 10 while draining
    do_reset();
    expect_pc(0, 2);
    pulse_start();
    deliver(2, c);
    cyc(1);
    @(negedge clk);
    chk("t5 busy in drain", busy, 1);
    chk("t5 halted in drain", halted, 0);
    chk("t5 head pc", inst_pc, 2);
    chk("t5 pc at halt", imem_addr, 3);
    cyc(1);
    redirect_valid = 1'b1; redirect_target = 5'd10; inst_ready = 1'b1;
    cyc(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t5 flushed", inst_valid, 0);
    chk("t5 halted after redirect", halted, 0);
    chk("t5 addr 10", imem_addr, 10);
    chk("t5 busy", busy, 1);
    expect_pc(10, 2);
    cyc(1);
    deliver(2, c);
    cyc(2);
    chk("t5 halted later", halted, 0);
    mem[3] = 9'd4;

    // Wrap past 31, then reset mid-stream
    do_reset();
    pulse_start();
    expect_pc(0, 34);
    deliver(34, c);
    chk("t6 cycles for 34", c, 35);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    @(negedge clk);
    chk("t6 rst valid", inst_valid, 0);
    chk("t6 rst addr", imem_addr, 0);
    chk("t6 rst busy", busy, 0);
    cyc(1);
    reset = 1'b0;
    cyc(3);
    @(negedge clk);
    chk("t6 idle valid", inst_valid, 0);
    chk("t6 idle busy", busy, 0);

    // Redirect in IDLE ignored; start beats a same-cycle redirect
    cyc(1);
    redirect_valid = 1'b1; redirect_target = 5'd9;
    cyc(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t7 idle redirect busy", busy, 0);
    chk("t7 idle redirect addr", imem_addr, 0);
    cyc(1);
    start = 1'b1; redirect_valid = 1'b1; redirect_target = 5'd15;
    cyc(1);
    start = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    chk("t7 start wins addr", imem_addr, 0);
    chk("t7 start wins busy", busy, 1);
    expect_pc(0, 2);
    cyc(1);
    deliver(2, c);

    cyc(2);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
